// File: rtl/ic1337_seq_pkg.sv
// Shared definitions for the ic1337 stimulus/check sequencer:
// FSM encoding and program-entry field layout.
package ic1337_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Program entry layout: {exp_Z, exp_Q1, exp_Q0, A2, A1, A0}
  localparam int A_LSB   = 0;
  localparam int A_W     = 3;
  localparam int EXP_LSB = 3;
  localparam int EXP_W   = 3;
  localparam int ENTRY_W = 6;

  function automatic logic [A_W-1:0] entry_a(input logic [ENTRY_W-1:0] e);
    return e[A_LSB +: A_W];
  endfunction

  function automatic logic [EXP_W-1:0] entry_exp(input logic [ENTRY_W-1:0] e);
    return e[EXP_LSB +: EXP_W];
  endfunction

endpackage

// File: rtl/ic1337_seq_mem.sv
// Program store for the sequencer: DEPTH x 6 register file,
// synchronous write, asynchronous read. Contents are intentionally not reset.
module ic1337_seq_mem
  import ic1337_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [ENTRY_W-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [ENTRY_W-1:0]         rdata
);

  logic [ENTRY_W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ic1337_sequencer.sv
// Programmable stimulus/check controller for the ic1337 flip-flop circuit:
// plays stored vectors onto the DUT and counts mismatching responses.
module ic1337_sequencer
  import ic1337_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LAT   = 1,
  parameter int CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       start,
  output logic [A_W-1:0]             dut_a,
  input  logic                       dut_q0,
  input  logic                       dut_q1,
  input  logic                       dut_z,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           err_cnt,
  output logic                       err_valid,
  output logic [$clog2(DEPTH)-1:0]   first_err_idx
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LEN_W = AW + 1;

  seq_state_t         state_r, state_s;
  logic [LEN_W-1:0]   len_r, len_clamp_s, step_r, step_s;
  logic [1:0]         drain_r, drain_s;
  logic               load_s, we_s, accept_s, mismatch_s;
  logic [AW-1:0]      rd_addr_s;
  logic [ENTRY_W-1:0] rd_data_s, rd_entry_s;
  logic [A_W-1:0]     dut_a_s, dut_a_r;
  logic               busy_r, done_r, err_valid_r;
  logic [CNT_W-1:0]   err_cnt_r;
  logic [AW-1:0]      first_err_idx_r;
  logic [LAT:0]       pv_r;
  logic [EXP_W-1:0]   pexp_r [LAT+1];
  logic [AW-1:0]      pidx_r [LAT+1];
  logic [EXP_W-1:0]   resp_s;

  assign we_s        = wr_en && (state_r == ST_IDLE);
  assign accept_s    = start && (state_r == ST_IDLE);
  assign len_clamp_s = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
  assign rd_addr_s   = (state_r == ST_IDLE) ? {AW{1'b0}} : step_r[AW-1:0];

  ic1337_seq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // A write in the start cycle lands at the same edge as the first load.
  assign rd_entry_s = (we_s && (wr_addr == rd_addr_s)) ? wr_data : rd_data_s;
  assign dut_a_s    = load_s ? entry_a(rd_entry_s) : 3'd0;
  assign resp_s     = {dut_z, dut_q1, dut_q0};
  assign mismatch_s = pv_r[LAT] && (resp_s != pexp_r[LAT]);

  // Next-state, step counter and load strobe
  always_comb begin
    state_s = state_r;
    step_s  = step_r;
    drain_s = drain_r;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (len_clamp_s == {LEN_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
            load_s  = 1'b1;
            step_s  = LEN_W'(1);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (step_r < len_r) begin
          load_s = 1'b1;
          step_s = step_r + LEN_W'(1);
        end else begin
          state_s = ST_DRAIN;
          drain_s = 2'd0;
        end
      end
      ST_DRAIN: begin
        if (drain_r == 2'(LAT - 1)) begin
          state_s = ST_DONE;
        end else begin
          drain_s = drain_r + 2'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        step_s  = {LEN_W{1'b0}};
      end
      default: begin
        state_s = ST_IDLE;
        step_s  = {LEN_W{1'b0}};
      end
    endcase
  end

  // FSM state and registered stimulus/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      step_r  <= {LEN_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      drain_r <= 2'd0;
      dut_a_r <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
      drain_r <= drain_s;
      dut_a_r <= dut_a_s;
      if (accept_s) begin
        len_r <= len_clamp_s;
      end
      // An empty run goes straight to DONE and never reports busy.
      busy_r  <= (state_s == ST_RUN) || (state_s == ST_DRAIN) ||
                 ((state_s == ST_DONE) && (state_r == ST_DRAIN));
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Expected-value pipeline aligned with the DUT response latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_r <= {(LAT+1){1'b0}};
      for (int i = 0; i <= LAT; i++) begin
        pexp_r[i] <= 3'd0;
        pidx_r[i] <= {AW{1'b0}};
      end
    end else begin
      pv_r      <= {pv_r[LAT-1:0], load_s};
      pexp_r[0] <= entry_exp(rd_entry_s);
      pidx_r[0] <= rd_addr_s;
      for (int i = 1; i <= LAT; i++) begin
        pexp_r[i] <= pexp_r[i-1];
        pidx_r[i] <= pidx_r[i-1];
      end
    end
  end

  // Mismatch counting and first-failure capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r       <= {CNT_W{1'b0}};
      err_valid_r     <= 1'b0;
      first_err_idx_r <= {AW{1'b0}};
    end else if (accept_s) begin
      err_cnt_r       <= {CNT_W{1'b0}};
      err_valid_r     <= 1'b0;
      first_err_idx_r <= {AW{1'b0}};
    end else if (mismatch_s) begin
      if (err_cnt_r != {CNT_W{1'b1}}) begin
        err_cnt_r <= err_cnt_r + CNT_W'(1);
      end
      if (!err_valid_r) begin
        err_valid_r     <= 1'b1;
        first_err_idx_r <= pidx_r[LAT];
      end
    end
  end

  assign dut_a         = dut_a_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err_cnt       = err_cnt_r;
  assign err_valid     = err_valid_r;
  assign first_err_idx = first_err_idx_r;

endmodule

// File: tb/tb_ic1337_sequencer.sv
// Scoreboard bench for ic1337_sequencer (DEPTH=8, LAT=1, CNT_W=2) driving
// a stand-in ic1337 flip-flop model.
module tb_ic1337_sequencer;

  logic       clk, rst_n, wr_en, start;
  logic [2:0] wr_addr, dut_a, first_err_idx;
  logic [5:0] wr_data;
  logic [3:0] len;
  logic       q0_m, q1_m, z_m;
  logic       busy, done, err_valid;
  logic [1:0] err_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [1:0] cnt;
    logic       v;
    logic [2:0] idx;
  } err_t;

  logic [2:0] a_q[$];
  err_t       err_q[$];
  logic [5:0] prog_m [8];

  ic1337_sequencer #(.DEPTH(8), .LAT(1), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .start(start), .dut_a(dut_a), .dut_q0(q0_m), .dut_q1(q1_m), .dut_z(z_m),
    .busy(busy), .done(done), .err_cnt(err_cnt), .err_valid(err_valid),
    .first_err_idx(first_err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ic1337: two flip-flops capturing A, Z decoded from their state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0_m <= 1'b0;
      q1_m <= 1'b0;
    end else begin
      q0_m <= dut_a[0] ^ dut_a[2];
      q1_m <= dut_a[1] | dut_a[0];
    end
  end
  assign z_m = q0_m & ~q1_m;

  function automatic logic [2:0] golden(input logic [2:0] a);
    logic q0, q1;
    q0 = a[0] ^ a[2];
    q1 = a[1] | a[0];
    return {q0 & ~q1, q1, q0};
  endfunction

  task automatic write_entry(input int addr, input logic [2:0] a, input logic [2:0] corrupt);
    prog_m[addr] = {golden(a) ^ corrupt, a};
    wr_en = 1'b1; wr_addr = 3'(addr); wr_data = prog_m[addr];
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic predict(input int l);
    int eff;
    err_t e;
    eff = (l > 8) ? 8 : l;
    e.cnt = 2'd0; e.v = 1'b0; e.idx = 3'd0;
    for (int k = 0; k < eff; k++) begin
      a_q.push_back(prog_m[k][2:0]);
      if (golden(prog_m[k][2:0]) !== prog_m[k][5:3]) begin
        if (e.cnt != 2'd3) e.cnt = e.cnt + 2'd1;
        if (!e.v) begin e.v = 1'b1; e.idx = 3'(k); end
      end
    end
    err_q.push_back(e);
  endtask

  task automatic run_check(input int l, input bit hold);
    int eff, target;
    bit got;
    err_t e;
    logic [2:0] ea;
    eff = (l > 8) ? 8 : l;
    target = (eff == 0) ? 1 : eff + 2;
    predict(l);
    len = 4'(l); start = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= target; c++) begin
      if (c <= eff) ea = a_q.pop_front(); else ea = 3'd0;
      tests_run++;
      if (dut_a !== ea) begin tests_failed++; $display("FAIL dut_a len%0d cyc%0d: got %0h expected %0h", l, c, dut_a, ea); end
      tests_run++;
      if (busy !== 1'(eff > 0)) begin tests_failed++; $display("FAIL busy len%0d cyc%0d: got %0b expected %0b", l, c, busy, eff > 0); end
      tests_run++;
      if (done !== 1'(c == target)) begin tests_failed++; $display("FAIL done len%0d cyc%0d: got %0b expected %0b", l, c, done, c == target); end
      if (c < target) begin @(posedge clk); #1; end
    end
    e = err_q.pop_front();
    tests_run++;
    if (err_cnt !== e.cnt) begin tests_failed++; $display("FAIL err_cnt len%0d: got %0d expected %0d", l, err_cnt, e.cnt); end
    tests_run++;
    if (err_valid !== e.v) begin tests_failed++; $display("FAIL err_valid len%0d: got %0b expected %0b", l, err_valid, e.v); end
    tests_run++;
    if (first_err_idx !== e.idx) begin tests_failed++; $display("FAIL first_err_idx len%0d: got %0d expected %0d", l, first_err_idx, e.idx); end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL after_done len%0d: got done=%0b busy=%0b expected 0 0", l, done, busy); end
    if (hold) begin
      @(posedge clk); #1;
      start = 1'b0;
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept: got busy=%0b expected 1", busy); end
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (done) begin got = 1'b1; break; end
        @(posedge clk); #1;
      end
      tests_run++;
      if (!got) begin tests_failed++; $display("FAIL b2b_done: got no done expected done within 20 cycles"); end
      tests_run++;
      if (err_cnt !== e.cnt) begin tests_failed++; $display("FAIL b2b_err_cnt: got %0d expected %0d", err_cnt, e.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    tests_run++;
    if (dut_a !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || err_cnt !== 2'd0 ||
        err_valid !== 1'b0 || first_err_idx !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got a=%0h busy=%0b done=%0b cnt=%0d v=%0b idx=%0d expected all 0",
               dut_a, busy, done, err_cnt, err_valid, first_err_idx);
    end
  endtask

  task automatic test_golden;
    write_entry(0, 3'b001, 3'b000);
    write_entry(1, 3'b110, 3'b000);
    write_entry(2, 3'b101, 3'b000);
    write_entry(3, 3'b011, 3'b000);
    run_check(4, 1'b0);
  endtask

  task automatic test_errors;
    write_entry(1, 3'b110, 3'b100);
    write_entry(3, 3'b011, 3'b100);
    run_check(4, 1'b0);
  endtask

  task automatic test_len_zero;
    run_check(0, 1'b0);
  endtask

  task automatic test_clamp;
    for (int k = 0; k < 8; k++) write_entry(k, 3'(k + 1), 3'b111);
    run_check(9, 1'b0);
  endtask

  task automatic test_write_during_run;
    bit got;
    len = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 6'b000_111;
    @(posedge clk); #1;
    wr_en = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL wr_run_done: got no done expected done within 20 cycles"); end
    @(posedge clk); #1;
    run_check(2, 1'b0);
  endtask

  task automatic test_start_with_write;
    prog_m[0] = {golden(3'b100), 3'b100};
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = prog_m[0];
    run_check(1, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_check(2, 1'b1);
  endtask

  task automatic test_reset_mid_run;
    len = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL post_reset cyc%0d: got done=%0b busy=%0b expected 0 0", i, done, busy);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; start = 1'b0;
    wr_addr = 3'd0; wr_data = 6'd0; len = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_golden();
    test_errors();
    test_len_zero();
    test_clamp();
    test_write_during_run();
    test_start_with_write();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
